// File: rtl/mult_rr_scheduler_if.sv
// Bundle of requester, datapath and response signals around the shared multiplier scheduler.
// The scheduler connects through the master modport; the requesters, datapath and consumer use slave.
interface mult_rr_scheduler_if #(
  parameter int WIDTH = 32
);
  logic               req0_valid;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req0_ready;

  logic               req1_valid;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               req1_ready;

  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_load;
  logic [2*WIDTH-1:0] mul_product;

  logic               rsp_valid;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_product;
  logic               rsp_ready;

  logic               busy;

  modport master (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output mul_a, mul_b, mul_load,
    input  mul_product,
    output rsp_valid, rsp_id, rsp_product,
    input  rsp_ready,
    output busy
  );

  modport slave (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  mul_a, mul_b, mul_load,
    output mul_product,
    input  rsp_valid, rsp_id, rsp_product,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one sequential multiplier between two requesters.
// The datapath has no done flag, so a fixed iteration count decides when the product is captured.
module mult_rr_scheduler #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_rr_scheduler_if.master bus
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]   rsp_prod_q, rsp_prod_d;

  logic                 grant0;
  logic                 grant1;
  logic                 mul_load;
  logic                 rsp_valid;
  logic                 busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rsp_id_q   <= 1'b0;
      rsp_prod_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_prod_q <= rsp_prod_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_id_d   = rsp_id_q;
    rsp_prod_d = rsp_prod_q;
    mul_load   = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state_q != IDLE);

    // rst_n gates the grants because IDLE is also the state held during reset
    grant0 = rst_n && (state_q == IDLE) && bus.req0_valid &&
             (!prio_q || !bus.req1_valid);
    grant1 = rst_n && (state_q == IDLE) && bus.req1_valid &&
             (prio_q || !bus.req0_valid);

    unique case (state_q)
      IDLE: begin
        if (grant0) begin
          mul_a_d  = bus.req0_a;
          mul_b_d  = bus.req0_b;
          rsp_id_d = 1'b0;
          state_d  = LOAD;
        end else if (grant1) begin
          mul_a_d  = bus.req1_a;
          mul_b_d  = bus.req1_b;
          rsp_id_d = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        mul_load = 1'b1;
        cnt_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          rsp_prod_d = bus.mul_product;
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          prio_d  = ~rsp_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.mul_load    = mul_load;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_prod_q;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler with a behavioural multiplier stub.
module tb_mult_rr_scheduler;
  localparam int W  = 32;
  localparam int MC = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks   = 0;
  int failures = 0;

  mult_rr_scheduler_if #(.WIDTH(W)) bus_if ();

  mult_rr_scheduler #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  // Stub: product becomes visible just before the scheduler's capture edge, zero before that
  logic [2*W-1:0] stub_pend = '0;
  logic [2*W-1:0] stub_prod = '0;
  int             stub_cnt  = 0;
  always @(posedge clk) begin
    if (bus_if.mul_load) begin
      stub_pend <= 64'(bus_if.mul_a) * 64'(bus_if.mul_b);
      if (MC == 1) stub_prod <= 64'(bus_if.mul_a) * 64'(bus_if.mul_b);
      else         stub_prod <= '0;
      stub_cnt  <= MC - 1;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_prod <= stub_pend;
    end
  end
  assign bus_if.mul_product = stub_prod;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int n, output int loads);
    n = 0;
    loads = 0;
    do begin
      tick();
      n++;
      if (bus_if.mul_load) loads++;
    end while (!bus_if.rsp_valid && n < 200);
  endtask

  initial begin
    int n;
    int loads;
    bus_if.req0_valid = 1'b0;
    bus_if.req0_a     = '0;
    bus_if.req0_b     = '0;
    bus_if.req1_valid = 1'b0;
    bus_if.req1_a     = '0;
    bus_if.req1_b     = '0;
    bus_if.rsp_ready  = 1'b0;

    // Reset state, with both requesters asking
    #1 rst_n = 1'b0;
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", bus_if.req0_ready, 0);
    chk("rst_req1_ready", bus_if.req1_ready, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_rsp_valid", bus_if.rsp_valid, 0);
    chk("rst_mul_load", bus_if.mul_load, 0);
    chk("rst_mul_a", bus_if.mul_a, 0);
    chk("rst_mul_b", bus_if.mul_b, 0);
    chk("rst_rsp_id", bus_if.rsp_id, 0);
    chk("rst_rsp_product", bus_if.rsp_product, 0);
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single request 3*2
    bus_if.req0_a = 32'd3; bus_if.req0_b = 32'd2; bus_if.req0_valid = 1'b1;
    #1;
    chk("single_req0_ready", bus_if.req0_ready, 1);
    tick();
    chk("single_load", bus_if.mul_load, 1);
    chk("single_mul_a", bus_if.mul_a, 3);
    chk("single_mul_b", bus_if.mul_b, 2);
    chk("single_busy", bus_if.busy, 1);
    chk("single_ready_drop", bus_if.req0_ready, 0);
    bus_if.req0_valid = 1'b0;
    wait_rsp(n, loads);
    chk("single_latency", n, MC + 1);
    chk("single_load_once", loads, 0);
    chk("single_id", bus_if.rsp_id, 0);
    chk("single_product", bus_if.rsp_product, 6);
    chk("single_mul_a_held", bus_if.mul_a, 3);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    chk("single_rsp_done", bus_if.rsp_valid, 0);
    chk("single_idle", bus_if.busy, 0);

    // Simultaneous requests after reset: req0 first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_if.req0_a = 32'hC03; bus_if.req0_b = 32'h702; bus_if.req0_valid = 1'b1;
    bus_if.req1_a = 32'h40A; bus_if.req1_b = 32'h462; bus_if.req1_valid = 1'b1;
    #1;
    chk("sim_req0_ready", bus_if.req0_ready, 1);
    chk("sim_req1_ready", bus_if.req1_ready, 0);
    tick();
    bus_if.req0_valid = 1'b0;
    wait_rsp(n, loads);
    chk("sim0_latency", n, MC + 1);
    chk("sim0_id", bus_if.rsp_id, 0);
    chk("sim0_product", bus_if.rsp_product, 64'h542D06);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    chk("sim1_req1_ready", bus_if.req1_ready, 1);
    tick();
    bus_if.req1_valid = 1'b0;
    chk("sim1_mul_a", bus_if.mul_a, 32'h40A);
    wait_rsp(n, loads);
    chk("sim1_id", bus_if.rsp_id, 1);
    chk("sim1_product", bus_if.rsp_product, 64'h11B3D4);
    bus_if.rsp_ready = 1'b1;
    tick();

    // Fairness: both held, rsp_ready tied high
    bus_if.req0_a = 32'd5;  bus_if.req0_b = 32'd7;  bus_if.req0_valid = 1'b1;
    bus_if.req1_a = 32'd11; bus_if.req1_b = 32'd13; bus_if.req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_rsp(n, loads);
      chk($sformatf("fair%0d_interval", k), n, (k == 0) ? MC + 2 : MC + 3);
      chk($sformatf("fair%0d_id", k), bus_if.rsp_id, k % 2);
      chk($sformatf("fair%0d_product", k), bus_if.rsp_product, (k % 2 == 0) ? 64'd35 : 64'd143);
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    tick();
    bus_if.rsp_ready = 1'b0;
    chk("fair_idle", bus_if.busy, 0);

    // Backpressure in RESP, req0 waiting with its next operation
    bus_if.req0_a = 32'h1234; bus_if.req0_b = 32'h10; bus_if.req0_valid = 1'b1;
    #1;
    tick();
    bus_if.req0_valid = 1'b0;
    wait_rsp(n, loads);
    chk("bp_latency", n, MC + 1);
    bus_if.req0_a = 32'd9; bus_if.req0_b = 32'd9; bus_if.req0_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("bp%0d_valid", k), bus_if.rsp_valid, 1);
      chk($sformatf("bp%0d_id", k), bus_if.rsp_id, 0);
      chk($sformatf("bp%0d_product", k), bus_if.rsp_product, 64'h12340);
      chk($sformatf("bp%0d_req0_ready", k), bus_if.req0_ready, 0);
      chk($sformatf("bp%0d_busy", k), bus_if.busy, 1);
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    chk("bp_rsp_done", bus_if.rsp_valid, 0);
    chk("bp_idle", bus_if.busy, 0);
    chk("bp_next_ready", bus_if.req0_ready, 1);

    // Reset mid-RUN with req0 still held
    tick();
    chk("abort_load", bus_if.mul_load, 1);
    chk("abort_mul_a", bus_if.mul_a, 9);
    repeat (10) tick();
    chk("abort_busy_run", bus_if.busy, 1);
    rst_n = 1'b0;
    bus_if.req1_valid = 1'b1;
    #1;
    chk("abort_busy", bus_if.busy, 0);
    chk("abort_mul_load", bus_if.mul_load, 0);
    chk("abort_mul_a_clr", bus_if.mul_a, 0);
    chk("abort_mul_b_clr", bus_if.mul_b, 0);
    chk("abort_rsp_product_clr", bus_if.rsp_product, 0);
    chk("abort_rsp_valid", bus_if.rsp_valid, 0);
    chk("abort_req0_ready", bus_if.req0_ready, 0);
    chk("abort_req1_ready", bus_if.req1_ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rearm_req0_ready", bus_if.req0_ready, 1);
    chk("rearm_req1_ready", bus_if.req1_ready, 0);
    tick();
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    wait_rsp(n, loads);
    chk("rearm_latency", n, MC + 1);
    chk("rearm_id", bus_if.rsp_id, 0);
    chk("rearm_product", bus_if.rsp_product, 64'd81);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;

    // Full-width operands
    bus_if.req1_a = 32'hFFFF_FFFF; bus_if.req1_b = 32'hFFFF_FFFF; bus_if.req1_valid = 1'b1;
    #1;
    chk("wide_req1_ready", bus_if.req1_ready, 1);
    tick();
    bus_if.req1_valid = 1'b0;
    wait_rsp(n, loads);
    chk("wide_latency", n, MC + 1);
    chk("wide_id", bus_if.rsp_id, 1);
    chk("wide_product", bus_if.rsp_product, 64'hFFFF_FFFE_0000_0001);
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    chk("wide_idle", bus_if.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Round-robin scheduler that shares one sequential 32x32->64 multiplier datapath (`mult_64bit`) between two requesters. It arbitrates requests and latches the winner's operands onto the datapath. It pulses a load strobe and counts a fixed number of iteration cycles, because the datapath has no done flag. It then captures the 64-bit product and returns it tagged with the requester ID over a valid/ready response channel.

## Interface
Parameters:
- `WIDTH`, 32, operand width; product is 2*WIDTH.
- `MUL_CYCLES`, 32, datapath latency in clocks from end of load cycle to valid product; legal range >= 1.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same for requester 1.
- `mul_a`, `mul_b`  out  WIDTH  operands driven to datapath.
- `mul_load`  out  1  one-cycle strobe; datapath restarts with `mul_a`/`mul_b`.
- `mul_product`  in  2*WIDTH  datapath result.
- `rsp_valid`  out  1  response available.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_product`  out  2*WIDTH  captured product.
- `rsp_ready`  in  1  consumer accepts response.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP. Priority register `prio` (1 bit). Iteration counter sized `$clog2(MUL_CYCLES+1)`.
- IDLE:
  - `reqN_ready` is combinational: `reqN_ready = IDLE & reqN_valid & (prio==N | ~req(other)_valid)`.
  - On an edge with a ready/valid handshake, latch the winner's a/b into `mul_a`/`mul_b`, latch the winner into `rsp_id`, and go to LOAD.
- LOAD:
  - `mul_load=1` for exactly one cycle and the counter clears.
  - Next state is RUN.
- RUN:
  - The counter increments every cycle.
  - On the edge where counter == MUL_CYCLES-1, capture `mul_product` into `rsp_product` and go to RESP.
- RESP:
  - `rsp_valid=1`; `rsp_id` and `rsp_product` are held stable until `rsp_ready`.
  - On the handshake edge, set `prio = ~rsp_id` and go to IDLE.
- Requester protocol:
  - A requester holds valid and operands stable until it sees ready.
  - Ready is never asserted outside IDLE, so at most one operation is in flight.
- Arbitration:
  - With a single valid requester, that requester wins regardless of `prio`.
  - When both are valid, `prio` decides.
  - If both are held continuously, grants strictly alternate.
- `mul_a`/`mul_b` stay constant from LOAD until the next acceptance.
- Width rule: `rsp_product` is the full 2*WIDTH value, unsigned, no truncation.
- Reset, including mid-operation:
  - All registers clear immediately and asynchronously.
  - Any in-flight operation is discarded and no response is produced.
  - `reqN_ready` is forced 0 while `rst_n`=0.

## Timing
- Reset values: state=IDLE, `prio`=0 (req0 preferred), `req0_ready`=`req1_ready`=0, `mul_a`=`mul_b`=0, `mul_load`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `busy`=0.
- Acceptance edge E0.
  - LOAD is the cycle E0..E1.
  - RUN covers edges E1..E(MUL_CYCLES+1).
  - `rsp_valid` rises after edge E(MUL_CYCLES+1). With the default parameters, that is 33 clocks after acceptance.
- Earliest re-acceptance is the first IDLE cycle after the response handshake edge. Minimum issue interval is MUL_CYCLES+3 clocks when `rsp_ready` is tied high.
- `busy` rises the cycle after acceptance and falls the cycle after the response handshake.
- A requester dropping valid in the same cycle as the other's handshake has no effect on the current grant.

## Test plan
A behavioral stub provides the multiplier: it registers a*b and presents it MUL_CYCLES clocks after `mul_load`. The stub is swappable for `mult_64bit` with a matching `MUL_CYCLES`.
- Single request: req0 a=3, b=2.
  - `req0_ready` pulses for one cycle.
  - `mul_load` pulses once with `mul_a`=3, `mul_b`=2.
  - `rsp_valid` rises MUL_CYCLES+1 edges after acceptance, with `rsp_id`=0 and `rsp_product`=6.
- Simultaneous requests after reset: req0 (0xC03, 0x702) and req1 (0x40A, 0x462).
  - req0 is served first with product 0x542D06.
  - req1 is served next with product 0x11B3D4 and `rsp_id`=1.
- Fairness: both requesters held valid for 6 operations -> `rsp_id` sequence is 0,1,0,1,0,1.
- Backpressure: `rsp_ready`=0 for 10 cycles in RESP.
  - `rsp_valid`, `rsp_id` and `rsp_product` stay stable.
  - `req0_ready`/`req1_ready` stay 0 and `busy` stays 1.
  - Release `rsp_ready` -> exactly one handshake, then IDLE.
- Reset mid-RUN: `rst_n` low 10 cycles after `mul_load`.
  - All outputs go to 0 without waiting for a clock edge.
  - No `rsp_valid` for the aborted operation.
  - After release, the held req0 is re-accepted with `prio`=0.
- Full-width operands: a=b=0xFFFFFFFF -> `rsp_product`=0xFFFFFFFE00000001.
